// File: rtl/digit_scan_if.sv
// -----------------------------------------------------------------------------
// digit_scan_if
//   Bundles the data-side signals of the digit scanner.
//   master : the producer of digit codes (drives digits_flat/digit_en[/dim_level],
//            observes the scan outputs).
//   slave  : the scanner itself.
//   Signals:
//     digits_flat  NUM_DIGITS*DATA_W  digit i = [i*DATA_W +: DATA_W]
//     digit_en     NUM_DIGITS         per-digit enable
//     dim_level    4                  brightness (only with DIGIT_SCAN_DIM_EN)
//     led_output   DATA_W             code of the current digit
//     an           NUM_DIGITS         one-hot anode select
//     digit_idx    clog2(NUM_DIGITS)  index of the current slot
//     frame_start  1                  pulse on entry to slot 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface digit_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4
);
  logic [NUM_DIGITS*DATA_W-1:0]   digits_flat;
  logic [NUM_DIGITS-1:0]          digit_en;
`ifdef DIGIT_SCAN_DIM_EN
  logic [3:0]                     dim_level;
`endif
  logic [DATA_W-1:0]              led_output;
  logic [NUM_DIGITS-1:0]          an;
  logic [$clog2(NUM_DIGITS)-1:0]  digit_idx;
  logic                           frame_start;

  modport master (
    output digits_flat, digit_en,
`ifdef DIGIT_SCAN_DIM_EN
    output dim_level,
`endif
    input  led_output, an, digit_idx, frame_start
  );

  modport slave (
    input  digits_flat, digit_en,
`ifdef DIGIT_SCAN_DIM_EN
    input  dim_level,
`endif
    output led_output, an, digit_idx, frame_start
  );
endinterface

// File: rtl/digit_scan_mux.sv
// -----------------------------------------------------------------------------
// digit_scan_mux
//   Time-multiplexed anode scanner for an N-digit seven-segment display.
//   A one-hot anode walks through NUM_DIGITS slots; each slot is lit for
//   ON_CYCLES clk_dv edges, then all anodes are dark for BLANK_CYCLES edges
//   (anti-ghosting). Digit codes and enables are snapshotted once per frame
//   on entry to slot 0 so a frame never mixes old and new data.
//
//   Optional feature macro: DIGIT_SCAN_DIM_EN
//     Adds bus.dim_level[3:0]; within a slot the anode is lit only while the
//     on-counter is below dim_level (sampled with the frame snapshot).
//
//   Ports:
//     clk_dv  in  scan clock
//     reset   in  asynchronous, active-high
//     bus     digit_scan_if.slave (digits_flat, digit_en[, dim_level] in;
//             led_output, an, digit_idx, frame_start out, all registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module digit_scan_mux #(
  parameter int NUM_DIGITS    = 4,
  parameter int DATA_W        = 4,
  parameter int ON_CYCLES     = 3,
  parameter int BLANK_CYCLES  = 1,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic         clk_dv,
  input  logic         reset,
  digit_scan_if.slave  bus
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_DIGITS*DATA_W-1:0]   snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]          snap_en_q, snap_en_d;
  logic [DATA_W-1:0]              led_q, led_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic                           fs_q, fs_d;
`ifdef DIGIT_SCAN_DIM_EN
  logic [3:0]                     snap_dim_q, snap_dim_d;
`endif

  logic                           enter_slot;
  logic [IDX_W-1:0]               next_idx;
  logic [IDX_W-1:0]               succ_idx;

  // Anode pattern for slot i: at most one bit active, polarity applied.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] i,
                                                      input logic lit);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    if (lit) oh[i] = 1'b1;
    return (AN_ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  assign succ_idx = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

  // NOTE: every variable gets its hold/default value first so no path through
  // the case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    snap_digits_d = snap_digits_q;
    snap_en_d     = snap_en_q;
    led_d         = led_q;
    an_d          = an_q;
    fs_d          = 1'b0;
`ifdef DIGIT_SCAN_DIM_EN
    snap_dim_d    = snap_dim_q;
`endif
    enter_slot    = 1'b0;
    next_idx      = idx_q;

    case (state_q)
      IDLE: begin
        // First edge after reset release behaves as a slot-0 entry.
        enter_slot = 1'b1;
        next_idx   = '0;
      end

      SHOW: begin
        if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
          if (BLANK_CYCLES == 0) begin
            enter_slot = 1'b1;
            next_idx   = succ_idx;
          end else begin
            state_d = BLANK;
            cnt_d   = '0;
            an_d    = AN_OFF;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef DIGIT_SCAN_DIM_EN
          // Anode tracks the on-counter value being loaded this edge.
          an_d = anode_for(idx_q, snap_en_q[idx_q] && (int'(cnt_d) < int'(snap_dim_q)));
`endif
        end
      end

      BLANK: begin
        if ((BLANK_CYCLES == 0) || (cnt_q == CNT_W'(BLANK_CYCLES - 1))) begin
          enter_slot = 1'b1;
          next_idx   = succ_idx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        an_d    = AN_OFF;
      end
    endcase

    if (enter_slot) begin
      // Slot 0 entry refreshes the frame snapshot; the new values are used
      // immediately for slot 0 and stay frozen for the rest of the frame.
      if (next_idx == '0) begin
        snap_digits_d = bus.digits_flat;
        snap_en_d     = bus.digit_en;
`ifdef DIGIT_SCAN_DIM_EN
        snap_dim_d    = bus.dim_level;
`endif
        fs_d          = 1'b1;
      end
      state_d = SHOW;
      idx_d   = next_idx;
      cnt_d   = '0;
      led_d   = snap_digits_d[int'(next_idx)*DATA_W +: DATA_W];
`ifdef DIGIT_SCAN_DIM_EN
      an_d    = anode_for(next_idx, snap_en_d[next_idx] && (snap_dim_d != 4'd0));
`else
      an_d    = anode_for(next_idx, snap_en_d[next_idx]);
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk_dv or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      led_q         <= '0;
      an_q          <= AN_OFF;
      fs_q          <= 1'b0;
`ifdef DIGIT_SCAN_DIM_EN
      snap_dim_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      led_q         <= led_d;
      an_q          <= an_d;
      fs_q          <= fs_d;
`ifdef DIGIT_SCAN_DIM_EN
      snap_dim_q    <= snap_dim_d;
`endif
    end
  end

  assign bus.led_output  = led_q;
  assign bus.an          = an_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_mux
//   Directed bench for digit_scan_mux. Two instances share stimulus:
//     dut    : ON=3, BLANK=1 (4-digit, active-low anodes)
//     dut_nb : ON=3, BLANK=0
//   Outputs are sampled 1 ns after each rising edge; "edge 1" is the first
//   rising edge after reset release. Expected vectors are {led, an, idx, fs}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_digit_scan_mux;

  logic clk_dv = 1'b0;
  logic reset  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_dv = ~clk_dv;

  digit_scan_if #(.NUM_DIGITS(4), .DATA_W(4)) bus_if ();
  digit_scan_if #(.NUM_DIGITS(4), .DATA_W(4)) nb_if ();

  assign nb_if.digits_flat = bus_if.digits_flat;
  assign nb_if.digit_en    = bus_if.digit_en;
`ifdef DIGIT_SCAN_DIM_EN
  assign nb_if.dim_level   = bus_if.dim_level;
`endif

  digit_scan_mux #(
    .NUM_DIGITS(4), .DATA_W(4), .ON_CYCLES(3), .BLANK_CYCLES(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk_dv (clk_dv),
    .reset  (reset),
    .bus    (bus_if)
  );

  digit_scan_mux #(
    .NUM_DIGITS(4), .DATA_W(4), .ON_CYCLES(3), .BLANK_CYCLES(0), .AN_ACTIVE_LOW(1)
  ) dut_nb (
    .clk_dv (clk_dv),
    .reset  (reset),
    .bus    (nb_if)
  );

  // Expected {led, an, idx, fs} at edge e of a scan with the given frame data.
  function automatic logic [10:0] exp_vec(input int e, input logic [15:0] d,
                                          input logic [3:0] en, input int on_c,
                                          input int bl_c, input int dim);
    int slot_len, p, slot, ph;
    logic [3:0] an_e, led_e;
    slot_len = on_c + bl_c;
    p        = (e - 1) % (4 * slot_len);
    slot     = p / slot_len;
    ph       = p % slot_len;
    led_e    = d[slot*4 +: 4];
    an_e     = 4'hF;
    if (ph < on_c && en[slot] && ph < dim) an_e[slot] = 1'b0;
    return {led_e, an_e, 2'(slot), (p == 0)};
  endfunction

  function automatic logic [10:0] got_vec();
    return {bus_if.led_output, bus_if.an, bus_if.digit_idx, bus_if.frame_start};
  endfunction

  function automatic logic [10:0] got_nb();
    return {nb_if.led_output, nb_if.an, nb_if.digit_idx, nb_if.frame_start};
  endfunction

  task automatic step();
    @(posedge clk_dv);
    #1;
  endtask

  // Leaves reset released just after an edge; the next rising edge is edge 1.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // At most one anode active on every edge, both instances.
  always @(negedge clk_dv) begin
    checks++;
    if ($countones(~bus_if.an) > 1 || $countones(~nb_if.an) > 1) begin
      failures++;
      $display("FAIL onehot t=%0t an=%b an_nb=%b required at most one zero",
               $time, bus_if.an, nb_if.an);
    end
  end

  task automatic test_reset();
    logic [10:0] g;
    reset = 1'b1;
    step();
    g = got_vec();
    checks++;
    if (g !== {4'h0, 4'hF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h required=%h", g, {4'h0, 4'hF, 2'd0, 1'b0});
    end
  endtask

  task automatic test_scan();
    logic [10:0] g, x;
    bus_if.digits_flat = 16'h4321;
    bus_if.digit_en    = 4'hF;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      step();
      g = got_vec();
      x = exp_vec(e, 16'h4321, 4'hF, 3, 1, 15);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL scan edge=%0d got=%h required=%h", e, g, x);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [10:0] g, x;
    bus_if.digits_flat = 16'h4321;
    bus_if.digit_en    = 4'hF;
    do_reset();
    for (int e = 1; e <= 21; e++) begin
      step();
      g = got_vec();
      x = exp_vec(e, (e <= 16) ? 16'h4321 : 16'h8765, 4'hF, 3, 1, 15);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL snapshot edge=%0d got=%h required=%h", e, g, x);
      end
      if (e == 6) bus_if.digits_flat = 16'h8765;
    end
  endtask

  task automatic test_digit_en();
    logic [10:0] g, x;
    bus_if.digits_flat = 16'h4321;
    bus_if.digit_en    = 4'b0101;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      step();
      g = got_vec();
      x = exp_vec(e, 16'h4321, 4'b0101, 3, 1, 15);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL digit_en edge=%0d got=%h required=%h", e, g, x);
      end
    end
    bus_if.digit_en = 4'hF;
  endtask

  task automatic test_reset_mid();
    logic [10:0] g;
    bus_if.digits_flat = 16'h4321;
    bus_if.digit_en    = 4'hF;
    do_reset();
    for (int e = 1; e <= 6; e++) step();
    #2;
    reset = 1'b1;
    #1;
    g = got_vec();
    checks++;
    if (g !== {4'h0, 4'hF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got=%h required=%h", g, {4'h0, 4'hF, 2'd0, 1'b0});
    end
    step();
    reset = 1'b0;
    step();
    g = got_vec();
    checks++;
    if (g !== {4'h1, 4'b1110, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_restart got=%h required=%h", g, {4'h1, 4'b1110, 2'd0, 1'b1});
    end
  endtask

  task automatic test_no_blank();
    logic [10:0] g, x;
    bus_if.digits_flat = 16'hA5C3;
    bus_if.digit_en    = 4'hF;
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      step();
      g = got_nb();
      x = exp_vec(e, 16'hA5C3, 4'hF, 3, 0, 15);
      checks++;
      if (g !== x || nb_if.an === 4'hF) begin
        failures++;
        $display("FAIL no_blank edge=%0d got=%h required=%h", e, g, x);
      end
    end
  endtask

`ifdef DIGIT_SCAN_DIM_EN
  task automatic test_dim();
    logic [10:0] g, x;
    bus_if.digits_flat = 16'h4321;
    bus_if.digit_en    = 4'hF;
    bus_if.dim_level   = 4'd1;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      step();
      g = got_vec();
      x = exp_vec(e, 16'h4321, 4'hF, 3, 1, 1);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL dim1 edge=%0d got=%h required=%h", e, g, x);
      end
    end
    bus_if.dim_level = 4'd0;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      step();
      g = got_vec();
      x = exp_vec(e, 16'h4321, 4'hF, 3, 1, 0);
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL dim0 edge=%0d got=%h required=%h", e, g, x);
      end
    end
    bus_if.dim_level = 4'hF;
  endtask
`endif

  initial begin
    bus_if.digits_flat = '0;
    bus_if.digit_en    = '0;
`ifdef DIGIT_SCAN_DIM_EN
    bus_if.dim_level   = 4'hF;
`endif
    test_reset();
    test_scan();
    test_snapshot();
    test_digit_en();
    test_reset_mid();
    test_no_blank();
`ifdef DIGIT_SCAN_DIM_EN
    test_dim();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
